// File: rtl/spim_regacc_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the SPI register-access master.
package spim_regacc_ctrl_pkg;

    localparam logic [7:0] CMD_RD    = 8'h10;
    localparam logic [3:0] CMD_WR_HI = 4'h2;

    localparam int LEN_CMD   = 8;
    localparam int LEN_ADDR  = 32;
    localparam int LEN_WDATA = 32;
    localparam int LEN_DUMMY = 8;
    localparam int LEN_RDATA = 32;

    // Requester index width; sized for the largest supported NREQ of 4.
    localparam int IDX_W = 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SETUP = 4'd1,
        ST_CMD   = 4'd2,
        ST_ADDR  = 4'd3,
        ST_WDATA = 4'd4,
        ST_DUMMY = 4'd5,
        ST_RWAIT = 4'd6,
        ST_RDATA = 4'd7,
        ST_HOLD  = 4'd8,
        ST_GAP   = 4'd9,
        ST_DONE  = 4'd10
    } state_e;

    function automatic logic [7:0] cmd_byte(input logic wr, input logic [3:0] be);
        logic [7:0] c;
        c = wr ? {CMD_WR_HI, be} : CMD_RD;
        return c;
    endfunction

    function automatic logic [5:0] field_last(input state_e st);
        logic [5:0] n;
        unique case (st)
            ST_CMD:   n = 6'(LEN_CMD - 1);
            ST_ADDR:  n = 6'(LEN_ADDR - 1);
            ST_WDATA: n = 6'(LEN_WDATA - 1);
            ST_DUMMY: n = 6'(LEN_DUMMY - 1);
            ST_RDATA: n = 6'(LEN_RDATA - 1);
            default:  n = 6'(LEN_CMD - 1);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/spim_rr_arb.sv
// Round-robin arbiter: search starts just after the last granted index; after reset index 0 wins first.
module spim_rr_arb
    import spim_regacc_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NREQ-1:0]  req_i,
    input  logic             advance_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] last_q, last_d;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req_i[j] && (j == (int'(last_q) + k) % NREQ)) begin
                    found      = 1'b1;
                    grant_o[j] = 1'b1;
                    idx_o      = IDX_W'(j);
                end
            end
        end
    end

    assign last_d = (advance_i && found) ? idx_o : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= IDX_W'(NREQ - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/spim_regacc_ctrl.sv
// SPI register-access master: arbitrates NREQ requesters and serialises each grant into
// a cmd/addr/wdata/dummy (write) or cmd/addr/dummy/rdata (read) SPI frame.
module spim_regacc_ctrl
    import spim_regacc_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int DIV_W = 8
) (
    input  logic               mclk,
    input  logic               reset_n,
    input  logic [DIV_W-1:0]   cfg_clk_div,
    input  logic [DIV_W-1:0]   cfg_rd_wait,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [4*NREQ-1:0]  req_be,
    input  logic [32*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ack,
    output logic [31:0]        rdata,
    output logic               busy,
    output logic               spi_clk,
    output logic               spi_sel_n,
    output logic               spi_din,
    input  logic               spi_dout
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             half_q, half_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [DIV_W-1:0] clk_div_q, clk_div_d;
    logic [DIV_W-1:0] rd_wait_q, rd_wait_d;
    logic             wr_q, wr_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      tx_q, tx_d;
    logic [31:0]      rx_q, rx_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_adv;
    logic             timed;
    logic             tick;

    logic             sel_wr;
    logic [3:0]       sel_be;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;

    assign arb_adv = (state_q == ST_IDLE) && (|req_valid);

    spim_rr_arb #(
        .NREQ(NREQ)
    ) u_arb (
        .clk_i    (mclk),
        .rst_ni   (reset_n),
        .req_i    (req_valid),
        .advance_i(arb_adv),
        .grant_o  (arb_gnt),
        .idx_o    (arb_idx)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_wr    = req_wr[i];
                sel_be    = req_be[4*i +: 4];
                sel_addr  = req_addr[32*i +: 32];
                sel_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Half-period divider only runs while a frame is in its timed states.
    assign timed = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign tick  = timed && (div_cnt_q == clk_div_q);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = '0;
        wait_cnt_d = wait_cnt_q;
        half_d     = half_q;
        bit_cnt_d  = bit_cnt_q;
        gnt_idx_d  = gnt_idx_q;
        rdata_d    = rdata_q;
        clk_div_d  = clk_div_q;
        rd_wait_d  = rd_wait_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        rx_d       = rx_q;

        if (timed) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d   = ST_SETUP;
                    gnt_idx_d = arb_idx;
                    clk_div_d = cfg_clk_div;
                    rd_wait_d = cfg_rd_wait;
                    wr_d      = sel_wr;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    tx_d      = {cmd_byte(sel_wr, sel_be), 24'h0};
                    half_d    = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (tick) state_d = ST_CMD;
            end
            ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY, ST_RDATA: begin
                if (tick) begin
                    half_d = ~half_q;
                    if (!half_q) begin
                        // This tick raises spi_clk: the slave's bit is sampled here.
                        if (state_q == ST_RDATA) rx_d = {rx_q[30:0], spi_dout};
                    end else if (bit_cnt_q == field_last(state_q)) begin
                        bit_cnt_d = '0;
                        unique case (state_q)
                            ST_CMD: begin
                                state_d = ST_ADDR;
                                tx_d    = addr_q;
                            end
                            ST_ADDR: begin
                                state_d = wr_q ? ST_WDATA : ST_DUMMY;
                                tx_d    = wr_q ? wdata_q : 32'h0;
                            end
                            ST_WDATA: begin
                                state_d = ST_DUMMY;
                                tx_d    = 32'h0;
                            end
                            ST_DUMMY: begin
                                wait_cnt_d = rd_wait_q;
                                if (wr_q)                 state_d = ST_HOLD;
                                else if (rd_wait_q == '0) state_d = ST_RDATA;
                                else                      state_d = ST_RWAIT;
                            end
                            default: state_d = ST_HOLD;
                        endcase
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = {tx_q[30:0], 1'b0};
                    end
                end
            end
            ST_RWAIT: begin
                if (tick) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                    if (wait_cnt_q == DIV_W'(1)) state_d = ST_RDATA;
                end
            end
            ST_HOLD: begin
                if (tick) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_DONE;
                    if (!wr_q) rdata_d = rx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            wait_cnt_q <= '0;
            half_q     <= 1'b0;
            bit_cnt_q  <= '0;
            gnt_idx_q  <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            half_q     <= half_d;
            bit_cnt_q  <= bit_cnt_d;
            gnt_idx_q  <= gnt_idx_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge mclk) begin
        clk_div_q <= clk_div_d;
        rd_wait_q <= rd_wait_d;
        wr_q      <= wr_d;
        addr_q    <= addr_d;
        wdata_q   <= wdata_d;
        tx_q      <= tx_d;
        rx_q      <= rx_d;
    end

    always_comb begin
        spi_clk   = 1'b1;
        spi_sel_n = 1'b1;
        spi_din   = 1'b1;
        unique case (state_q)
            ST_SETUP, ST_RWAIT, ST_HOLD: begin
                spi_sel_n = 1'b0;
                spi_din   = tx_q[31];
            end
            ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY, ST_RDATA: begin
                spi_sel_n = 1'b0;
                spi_clk   = half_q;
                spi_din   = tx_q[31];
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ack[i] = (state_q == ST_DONE) && (gnt_idx_q == IDX_W'(i));
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_spim_regacc_ctrl.sv
// Directed bench for spim_regacc_ctrl: a vector table of single transactions plus
// hand-written reset-in-frame and two-requester round-robin sequences.
module tb_spim_regacc_ctrl;

    localparam int NREQ  = 2;
    localparam int DIV_W = 8;

    logic                 mclk = 1'b0;
    logic                 reset_n;
    logic [DIV_W-1:0]     cfg_clk_div;
    logic [DIV_W-1:0]     cfg_rd_wait;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_wr;
    logic [4*NREQ-1:0]    req_be;
    logic [32*NREQ-1:0]   req_addr;
    logic [32*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]      req_ack;
    logic [31:0]          rdata;
    logic                 busy;
    logic                 spi_clk;
    logic                 spi_sel_n;
    logic                 spi_din;
    logic                 spi_dout;

    spim_regacc_ctrl #(
        .NREQ (NREQ),
        .DIV_W(DIV_W)
    ) dut (
        .mclk       (mclk),
        .reset_n    (reset_n),
        .cfg_clk_div(cfg_clk_div),
        .cfg_rd_wait(cfg_rd_wait),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_be     (req_be),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ack    (req_ack),
        .rdata      (rdata),
        .busy       (busy),
        .spi_clk    (spi_clk),
        .spi_sel_n  (spi_sel_n),
        .spi_din    (spi_din),
        .spi_dout   (spi_dout)
    );

    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI slave / line monitor, sampled on the falling mclk edge.
    logic [31:0]  slave_data = 32'h0;
    logic [31:0]  slave_sh;
    logic [127:0] bits, last_bits;
    int rises = 0, falls = 0, hi_run = 0;
    int last_rises = 0, last_hi = 0;
    int frames = 0;
    int sel_hi_run = 0;
    int gap_min = 1000000;
    logic prev_clk = 1'b1;
    logic prev_sel_n = 1'b1;

    always @(negedge mclk) begin
        if (!spi_sel_n && prev_sel_n) begin
            if (frames > 0 && sel_hi_run < gap_min) gap_min = sel_hi_run;
            rises    = 0;
            falls    = 0;
            hi_run   = 0;
            bits     = '0;
            slave_sh = slave_data;
            spi_dout = 1'b0;
        end
        if (!spi_sel_n) begin
            if (spi_clk && !prev_clk) begin
                rises++;
                bits = {bits[126:0], spi_din};
            end
            if (!spi_clk && prev_clk) begin
                falls++;
                if (falls > 48) begin
                    spi_dout = slave_sh[31];
                    slave_sh = {slave_sh[30:0], 1'b0};
                end
            end
            if (rises == 48 && spi_clk) hi_run++;
            sel_hi_run = 0;
        end else begin
            sel_hi_run++;
        end
        if (spi_sel_n && !prev_sel_n) begin
            frames++;
            last_bits  = bits;
            last_rises = rises;
            last_hi    = hi_run;
        end
        prev_clk   = spi_clk;
        prev_sel_n = spi_sel_n;
    end

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  div;
        logic [7:0]  rwait;
        logic [31:0] sdata;
        int          idx;
        logic        drop;
        logic [7:0]  exp_cmd;
        int          exp_cyc;
    } vec_t;

    logic [31:0] exp_rdata = 32'h0;

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        int f0;
        bit got;
        logic [NREQ-1:0] ack_s;
        logic busy_s;
        logic [31:0] rd_s;
        logic [NREQ-1:0] exp_ack;
        ack_s  = '0;
        busy_s = 1'b0;
        rd_s   = '0;
        @(negedge mclk);
        cfg_clk_div = v.div;
        cfg_rd_wait = v.rwait;
        req_wr[v.idx]            = v.wr;
        req_be[4*v.idx +: 4]     = v.be;
        req_addr[32*v.idx +: 32] = v.addr;
        req_wdata[32*v.idx +: 32] = v.wdata;
        slave_data = v.sdata;
        f0 = frames;
        req_valid = '0;
        req_valid[v.idx] = 1'b1;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 4000) begin
            @(posedge mclk);
            @(negedge mclk);
            cyc++;
            if (cyc == 10) begin
                cfg_clk_div = v.div + 8'd2;
                cfg_rd_wait = v.rwait + 8'd3;
            end
            if (v.drop && cyc == 20) req_valid = '0;
            if (req_ack != '0) begin
                got    = 1'b1;
                ack_s  = req_ack;
                busy_s = busy;
                rd_s   = rdata;
            end
        end
        req_valid = '0;
        if (!got) begin
            check({tag, " ack_timeout"}, 64'(cyc), 64'(v.exp_cyc));
            return;
        end
        if (!v.wr) exp_rdata = v.sdata;
        exp_ack = '0;
        exp_ack[v.idx] = 1'b1;
        check({tag, " ack_cycle"}, 64'(cyc), 64'(v.exp_cyc));
        check({tag, " ack_onehot"}, 64'(ack_s), 64'(exp_ack));
        check({tag, " busy_at_ack"}, 64'(busy_s), 64'd1);
        check({tag, " rdata_at_ack"}, 64'(rd_s), 64'(exp_rdata));
        @(posedge mclk);
        @(negedge mclk);
        check({tag, " ack_after"}, 64'(req_ack), 64'd0);
        check({tag, " busy_after"}, 64'(busy), 64'd0);
        check({tag, " frames"}, 64'(frames - f0), 64'd1);
        check({tag, " rises"}, 64'(last_rises), 64'd80);
        check({tag, " cmd"}, 64'(last_bits[79:72]), 64'(v.exp_cmd));
        check({tag, " addr"}, 64'(last_bits[71:40]), 64'(v.addr));
        if (v.wr) begin
            check({tag, " wdata"}, 64'(last_bits[39:8]), 64'(v.wdata));
            check({tag, " dummy"}, 64'(last_bits[7:0]), 64'd0);
        end else begin
            check({tag, " dummy"}, 64'(last_bits[39:32]), 64'd0);
            check({tag, " din_in_rdata"}, 64'(last_bits[31:0]), 64'd0);
            // Last dummy high half plus the read-wait half-periods.
            check({tag, " rwait_high"}, 64'(last_hi), 64'((v.rwait + 1) * (v.div + 1)));
        end
    endtask

    vec_t vecs[6];
    vec_t v6;
    logic [NREQ-1:0] rr_exp[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //             wr    be     addr          wdata         div   rwait sdata         idx drop  cmd    cycles
        vecs[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A, 8'd0, 8'd0, 32'h0,         0, 1'b0, 8'h2F, 165};
        vecs[1] = '{1'b0, 4'hF, 32'h3000_0000, 32'h0,         8'd0, 8'd0, 32'h1234_5678, 0, 1'b0, 8'h10, 165};
        vecs[2] = '{1'b0, 4'hF, 32'h0000_ABCC, 32'h0,         8'd3, 8'd4, 32'h8765_4321, 1, 1'b0, 8'h10, 670};
        vecs[3] = '{1'b1, 4'h3, 32'h0000_0010, 32'h0000_00FF, 8'd0, 8'd0, 32'h0,         1, 1'b0, 8'h23, 165};
        vecs[4] = '{1'b1, 4'h0, 32'h0000_0010, 32'h0000_00FF, 8'd1, 8'd0, 32'h0,         0, 1'b1, 8'h20, 328};
        vecs[5] = '{1'b0, 4'h5, 32'h8000_1230, 32'h0,         8'd1, 8'd2, 32'hDEAD_BEEF, 1, 1'b0, 8'h10, 332};
        v6      = '{1'b0, 4'hF, 32'h3000_0008, 32'h0,         8'd0, 8'd0, 32'hCAFE_F00D, 0, 1'b0, 8'h10, 165};
        rr_exp[0] = 2'b01;
        rr_exp[1] = 2'b10;
        rr_exp[2] = 2'b01;

        reset_n     = 1'b0;
        cfg_clk_div = '0;
        cfg_rd_wait = '0;
        req_valid   = '0;
        req_wr      = '0;
        req_be      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        repeat (3) @(negedge mclk);
        check("rst spi_clk", 64'(spi_clk), 64'd1);
        check("rst sel_n", 64'(spi_sel_n), 64'd1);
        check("rst din", 64'(spi_din), 64'd1);
        check("rst ack", 64'(req_ack), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst rdata", 64'(rdata), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge mclk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the address field is being shifted.
        @(negedge mclk);
        cfg_clk_div = 8'd0;
        cfg_rd_wait = 8'd0;
        req_wr[0] = 1'b0;
        req_addr[31:0] = 32'h3000_0000;
        req_valid = 2'b01;
        repeat (30) @(negedge mclk);
        check("pre_rst sel_n", 64'(spi_sel_n), 64'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst sel_n", 64'(spi_sel_n), 64'd1);
        check("mid_rst spi_clk", 64'(spi_clk), 64'd1);
        check("mid_rst din", 64'(spi_din), 64'd1);
        check("mid_rst ack", 64'(req_ack), 64'd0);
        check("mid_rst busy", 64'(busy), 64'd0);
        check("mid_rst rdata", 64'(rdata), 64'd0);
        req_valid = '0;
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        exp_rdata = 32'h0;
        repeat (2) @(negedge mclk);
        run_vec(v6, "post_rst");

        // Two requesters held together after a fresh reset.
        @(negedge mclk);
        reset_n = 1'b0;
        @(negedge mclk);
        reset_n = 1'b1;
        @(negedge mclk);
        cfg_clk_div = 8'd1;
        cfg_rd_wait = 8'd0;
        req_wr    = 2'b11;
        req_be    = 8'hFF;
        req_addr  = {32'h0000_0200, 32'h0000_0100};
        req_wdata = {32'h2222_2222, 32'h1111_1111};
        gap_min   = 1000000;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            int waited;
            waited = 0;
            do begin
                @(posedge mclk);
                @(negedge mclk);
                waited++;
            end while (req_ack == '0 && waited < 2000);
            check($sformatf("rr grant%0d", k), 64'(req_ack), 64'(rr_exp[k]));
        end
        req_valid = '0;
        check("rr gap_ok", 64'(gap_min >= 2), 64'd1);

        repeat (4) @(negedge mclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
